par_gen_tx: RTL and testbench

PAR_GEN_TX -- requirements
Module: par_gen_tx

---
 rtl/par_gen_tx_if.sv | 23 ++
 rtl/par_gen_tx.sv | 95 +++++++++
 tb/tb_par_gen_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/par_gen_tx_if.sv
// Byte-in / frame-out bundle for the parity frame transmitter.
// master drives the data byte; slave is the transmitter.
interface par_gen_tx_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [8:0] frame;
    logic       frame_valid;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic [7:0] tx_count;

    modport master (
        output din, din_valid,
        input  din_ready, frame, frame_valid, sout, sout_valid, busy, tx_count
    );

    modport slave (
        input  din, din_valid,
        output din_ready, frame, frame_valid, sout, sout_valid, busy, tx_count
    );
endinterface

// File: rtl/par_gen_tx.sv
// Parity frame transmitter: latches {parity, byte} on handshake, then shifts
// the 9-bit frame out LSB first, one bit per cycle.
module par_gen_tx #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    par_gen_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t     r_state;
    logic [3:0] r_bit_idx;
    logic [8:0] r_frame;
    logic       r_frame_valid;
    logic       r_sout;
    logic       r_sout_valid;
    logic       r_busy;
    logic       r_din_ready;
    logic [7:0] r_tx_count;

    logic       w_accept;
    logic       w_parity;
    logic [3:0] w_next_idx;

    // din_ready is only ever 1 in IDLE, so it alone qualifies acceptance
    assign w_accept   = r_din_ready & bus.din_valid;
    assign w_parity   = (^bus.din) ^ PARITY_ODD;
    assign w_next_idx = r_bit_idx + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_bit_idx     <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_sout        <= 1'b0;
            r_sout_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_din_ready   <= 1'b0;
            r_tx_count    <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= SHIFT;
                        r_bit_idx     <= '0;
                        r_frame       <= {w_parity, bus.din};
                        r_frame_valid <= 1'b1;
                        r_sout        <= bus.din[0];
                        r_sout_valid  <= 1'b1;
                        r_busy        <= 1'b1;
                        r_din_ready   <= 1'b0;
                    end else begin
                        r_din_ready   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_bit_idx == 4'd8) begin
                        r_state      <= IDLE;
                        r_bit_idx    <= '0;
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_din_ready  <= 1'b1;
                        r_tx_count   <= r_tx_count + 8'd1;
                    end else begin
                        r_bit_idx    <= w_next_idx;
                        r_sout       <= r_frame[w_next_idx];
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_bit_idx    <= '0;
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_din_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready   = r_din_ready;
    assign bus.frame       = r_frame;
    assign bus.frame_valid = r_frame_valid;
    assign bus.sout        = r_sout;
    assign bus.sout_valid  = r_sout_valid;
    assign bus.busy        = r_busy;
    assign bus.tx_count    = r_tx_count;
endmodule

// File: tb/tb_par_gen_tx.sv
// Scoreboard bench for par_gen_tx: even- and odd-parity instances share the
// same randomized stimulus; per-instance monitors check every cycle.
module tb_par_gen_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [8:0] exp_q [2][$];

    always #5 clk = ~clk;

    par_gen_tx_if ifc [2] ();

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference frame: parity bit chosen so the 9-bit frame's ones count
    // is even (odd = 0) or odd (odd = 1).
    function automatic logic [8:0] ref_frame(input logic [7:0] d, input bit odd);
        int unsigned ones;
        logic p;
        ones = $countones(d);
        p = ((ones % 2) == 1) != odd;
        return {p, d};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        par_gen_tx #(.PARITY_ODD(g == 1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc[g])
        );

        logic [8:0] cur    = '0;
        int         idx    = 0;
        bit         active = 1'b0;
        logic [7:0] txe    = '0;

        always @(negedge clk) begin
            if (!rst) begin
                chk("reset_outputs",
                    32'({ifc[g].frame, ifc[g].frame_valid, ifc[g].sout, ifc[g].sout_valid,
                         ifc[g].busy, ifc[g].din_ready, ifc[g].tx_count}), 32'd0);
                cur = '0; idx = 0; active = 1'b0; txe = '0;
            end else begin
                chk("tx_count", 32'(ifc[g].tx_count), 32'(txe));
                if (ifc[g].frame_valid) begin
                    chk("frame_valid_spacing", 32'(active), 32'd0);
                    chk("frame_expected", 32'(exp_q[g].size() != 0), 32'd1);
                    if (exp_q[g].size() != 0) begin
                        cur = exp_q[g].pop_front();
                        chk("frame", 32'(ifc[g].frame), 32'(cur));
                    end
                    active = 1'b1;
                    idx = 0;
                end
                if (active) begin
                    chk("shift_bit",
                        32'({ifc[g].sout, ifc[g].sout_valid, ifc[g].busy, ifc[g].din_ready,
                             ifc[g].frame_valid, ifc[g].frame}),
                        32'({cur[idx], 1'b1, 1'b1, 1'b0, idx == 0, cur}));
                    idx++;
                    if (idx == 9) begin
                        active = 1'b0;
                        txe = txe + 8'd1;
                    end
                end else begin
                    chk("idle",
                        32'({ifc[g].sout, ifc[g].sout_valid, ifc[g].busy, ifc[g].din_ready,
                             ifc[g].frame_valid, ifc[g].frame}),
                        32'({5'b00010, cur}));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        ifc[0].din_valid = v;
        ifc[1].din_valid = v;
        ifc[0].din = d;
        ifc[1].din = d;
    endtask

    // One cycle of stimulus; the handshake the DUT will see at the next edge
    // is predicted from the ready level it presents now.
    task automatic step(input logic v, input logic [7:0] d, output logic accepted);
        @(negedge clk);
        #1;
        drive(v, d);
        accepted = v && rst && ifc[0].din_ready;
        if (accepted) begin
            exp_q[0].push_back(ref_frame(d, 1'b0));
            exp_q[1].push_back(ref_frame(d, 1'b1));
        end
    endtask

    task automatic idle(input int unsigned n);
        logic a;
        for (int unsigned i = 0; i < n; i++) step(1'b0, 8'($urandom), a);
    endtask

    task automatic send(input logic [7:0] d);
        logic a;
        int unsigned n;
        a = 1'b0;
        n = 0;
        do begin
            step(1'b1, d, a);
            n++;
        end while (!a && n < 20);
        chk("accepted", 32'(a), 32'd1);
    endtask

    task automatic directed(input logic [8:0] exp_even, input logic [8:0] exp_odd);
        @(posedge clk);
        #1;
        chk("directed_even", 32'({ifc[0].frame_valid, ifc[0].frame}), 32'({1'b1, exp_even}));
        chk("directed_odd",  32'({ifc[1].frame_valid, ifc[1].frame}), 32'({1'b1, exp_odd}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 8'h00);
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic a;
        int   prev;
        drive(1'b0, 8'h00);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        send(8'hA5); directed(9'h0A5, 9'h1A5); idle(12);
        send(8'h07); directed(9'h107, 9'h007); idle(12);
        send(8'h00); directed(9'h000, 9'h100);
        send(8'hFF); directed(9'h0FF, 9'h1FF); idle(12);

        // din_valid held high, din changing every cycle
        prev = -1;
        for (int i = 0; i < 35; i++) begin
            step(1'b1, 8'($urandom), a);
            if (a) begin
                if (prev >= 0) chk("accept_spacing", 32'(i - prev), 32'd10);
                prev = i;
            end
        end
        idle(12);

        // reset during bit 4 of a frame
        send(8'h5A);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1'b0, 8'h00);
        #1;
        chk("abort_even", 32'({ifc[0].sout, ifc[0].sout_valid, ifc[0].busy, ifc[0].tx_count}), 32'd0);
        chk("abort_odd",  32'({ifc[1].sout, ifc[1].sout_valid, ifc[1].busy, ifc[1].tx_count}), 32'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        @(negedge clk);
        #1 rst = 1'b1;
        send(8'h3C); directed(9'h03C, 9'h13C); idle(12);

        // 256 frames from a fresh counter: tx_count must wrap back to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(8'($urandom));
            if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
        end
        idle(15);
        chk("tx_wrap_even", 32'(ifc[0].tx_count), 32'd0);
        chk("tx_wrap_odd",  32'(ifc[1].tx_count), 32'd0);
        chk("queue_empty_even", 32'(exp_q[0].size()), 32'd0);
        chk("queue_empty_odd",  32'(exp_q[1].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
